// File: rtl/pipe_front_regs_pkg.sv
// Shared constants and types for the front-end pipeline register block.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_STEP   = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // Front-end sequencing state; encoding 3 is unused and recovers to RUN.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HELD   = 2'd1,
    REFILL = 2'd2
  } front_state_t;

  // Bit positions inside the packed ID-stage control bundle.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;

endpackage

// File: rtl/pipe_front_regs_if.sv
// Handshake/bus signals between the front-end register block and the rest of the core.
interface pipe_front_regs_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 8,
  parameter int CNT_W   = 16
);

  logic               stall;
  logic               flush;
  logic [ADDR_W-1:0]  branch_target;
  logic [INSTR_W-1:0] instr_in;
  logic [CTRL_W-1:0]  ctrl_in;
  logic               memread_in;

  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc4;
  logic               ifid_valid;
  logic [CTRL_W-1:0]  idex_ctrl;
  logic               idex_memread;
  logic [4:0]         idex_rt;
  logic               idex_valid;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
  logic               hang_err;
  logic [1:0]         state;

  // Surrounding core: hazard unit, branch unit, instruction memory, control unit.
  modport master (
    output stall, flush, branch_target, instr_in, ctrl_in, memread_in,
    input  pc, ifid_instr, ifid_pc4, ifid_valid, idex_ctrl, idex_memread,
           idex_rt, idex_valid, stall_cnt, flush_cnt, hang_err, state
  );

  // The register block itself.
  modport slave (
    input  stall, flush, branch_target, instr_in, ctrl_in, memread_in,
    output pc, ifid_instr, ifid_pc4, ifid_valid, idex_ctrl, idex_memread,
           idex_rt, idex_valid, stall_cnt, flush_cnt, hang_err, state
  );

endinterface

// File: rtl/pipe_front_regs_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: PC, IF/ID and the control half of ID/EX,
// with stall bubbling, branch redirect/squash, statistics and a stall watchdog.
module pipe_front_regs
  import pipe_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int INSTR_W   = 32,
  parameter int CTRL_W    = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_front_regs_if.slave  bus
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pcPlus4;
  logic [ADDR_W-1:0]  targetAligned;
  logic [INSTR_W-1:0] ifidInstr;
  logic [ADDR_W-1:0]  ifidPc4;
  logic               ifidValid;
  logic [CTRL_W-1:0]  idexCtrl;
  logic               idexMemread;
  logic [4:0]         idexRt;
  logic               idexValid;
  logic [RUN_W-1:0]   runCnt;
  logic               hangErr;
  logic               flushTaken;
  front_state_t       curState;

  assign pcPlus4       = pc + ADDR_W'(PC_STEP);
  assign targetAligned = bus.branch_target & ~ADDR_W'(3);
  // A flush that coincides with a stall is dropped; the branch unit re-asserts it.
  assign flushTaken    = bus.flush && !bus.stall;

  // PC, IF/ID and ID/EX registers with reset > stall > flush > normal priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= ADDR_W'(RESET_PC);
      ifidInstr   <= INSTR_W'(NOP_INSTR);
      ifidPc4     <= '0;
      ifidValid   <= 1'b0;
      idexCtrl    <= '0;
      idexMemread <= 1'b0;
      idexRt      <= '0;
      idexValid   <= 1'b0;
    end else if (bus.stall) begin
      idexCtrl    <= '0;
      idexMemread <= 1'b0;
      idexRt      <= ifidInstr[20:16];
      idexValid   <= 1'b0;
    end else begin
      pc          <= bus.flush ? targetAligned : pcPlus4;
      ifidInstr   <= bus.flush ? INSTR_W'(NOP_INSTR) : bus.instr_in;
      ifidPc4     <= pcPlus4;
      ifidValid   <= !bus.flush;
      idexCtrl    <= bus.ctrl_in;
      idexMemread <= bus.memread_in;
      idexRt      <= ifidInstr[20:16];
      idexValid   <= ifidValid;
    end
  end

  // Sequencing FSM and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= RUN;
      hangErr  <= 1'b0;
    end else begin
      case (curState)
        RUN, REFILL: begin
          if (bus.stall)      curState <= HELD;
          else if (bus.flush) curState <= REFILL;
          else                curState <= RUN;
        end
        HELD: begin
          if (bus.stall) begin
            curState <= HELD;
            if ((int'(runCnt) + 1) >= MAX_STALL) hangErr <= 1'b1;
          end else if (bus.flush) begin
            curState <= REFILL;
          end else begin
            curState <= RUN;
          end
        end
        default: curState <= RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (bus.stall),
    .count (bus.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (flushTaken),
    .count (bus.flush_cnt)
  );

  // Length of the current stall run: 1 on the first stalled edge, cleared when it ends.
  sat_counter #(.WIDTH(RUN_W)) u_run_cnt (
    .clk   (clk),
    .clr   (reset || !bus.stall),
    .inc   (bus.stall),
    .count (runCnt)
  );

  assign bus.pc           = pc;
  assign bus.ifid_instr   = ifidInstr;
  assign bus.ifid_pc4     = ifidPc4;
  assign bus.ifid_valid   = ifidValid;
  assign bus.idex_ctrl    = idexCtrl;
  assign bus.idex_memread = idexMemread;
  assign bus.idex_rt      = idexRt;
  assign bus.idex_valid   = idexValid;
  assign bus.hang_err     = hangErr;
  assign bus.state        = curState;

endmodule

// File: doc/pipe_front_regs.md
# pipe_front_regs

Front-end pipeline register block of the 5-stage MIPS core and the consumer of the hazard unit's `stall` output. It owns the PC, the IF/ID register and the control half of the ID/EX register. It holds PC and IF/ID while `stall` is asserted, injects an ID/EX bubble, and redirects and squashes the fetch on a taken branch. It feeds `idex_rt` and `idex_memread` back to the hazard unit, which closes the load-use loop, and it keeps saturating stall, flush and watchdog statistics.

## Interface
Parameters:
- `ADDR_W`, 32, PC and branch-target width.
- `INSTR_W`, 32, instruction width.
- `CTRL_W`, 8, width of the packed ID-stage control bundle. Bit 0 is RegWrite and bit 1 is MemWrite.
- `CNT_W`, 16, statistics counter width.
- `MAX_STALL`, 4, consecutive stall cycles allowed before `hang_err` is raised.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: load-use stall from the hazard unit, sampled at the same edge.
- `flush` in 1: branch taken, resolved in ID.
- `branch_target` in ADDR_W: redirect address.
- `instr_in` in INSTR_W: instruction memory data for the current `pc`.
- `ctrl_in` in CTRL_W: control bundle already gated by the hazard unit.
- `memread_in` in 1: MemRead from the control unit.
- `pc` out ADDR_W: fetch address.
- `ifid_instr` out INSTR_W.
- `ifid_pc4` out ADDR_W.
- `ifid_valid` out 1.
- `idex_ctrl` out CTRL_W.
- `idex_memread` out 1.
- `idex_rt` out 5.
- `idex_valid` out 1.
- `stall_cnt` out CNT_W.
- `flush_cnt` out CNT_W.
- `hang_err` out 1: sticky.
- `state` out 2: current FSM state.

## Operation
- **Reset values.** `pc`=0, `ifid_instr`=0 (NOP), `ifid_pc4`=0, `ifid_valid`=0, `idex_ctrl`=0, `idex_memread`=0, `idex_rt`=0, `idex_valid`=0, counters 0, `hang_err`=0, `state`=RUN.
- **Priority at each edge:** reset > stall > flush > normal.
  - Stall beats flush because a branch stalled in ID has unresolved operands. While `stall`=1, `flush` is ignored, and the source must re-assert it later.
- **Normal.**
  - `pc`←`pc`+4, wrapping modulo 2^ADDR_W.
  - `ifid_instr`←`instr_in`, `ifid_pc4`←`pc`+4, `ifid_valid`←1.
  - `idex_ctrl`←`ctrl_in`, `idex_memread`←`memread_in`, `idex_rt`←`ifid_instr[20:16]`, `idex_valid`←`ifid_valid`.
- **Stall.**
  - `pc` and the IF/ID registers hold.
  - `idex_ctrl`←0, `idex_memread`←0, `idex_valid`←0 (bubble). `idex_rt` is still loaded.
  - `stall_cnt` increments.
- **Flush.**
  - `pc`←`branch_target` with bits [1:0] forced to 0.
  - `ifid_instr`←0, `ifid_valid`←0.
  - ID/EX loads normally, so the branch itself proceeds.
  - `flush_cnt` increments.
- **Counters** saturate at all-ones and never wrap.
- **FSM.** Each entry lists the condition, the next state, and the actions.
  - RUN: `stall` → HELD, run counter←1. `flush` → REFILL. Otherwise stay in RUN.
  - HELD: `stall` → stay in HELD, run counter+1. If the run counter reaches `MAX_STALL`, set `hang_err`, which stays set until reset. `!stall && flush` → REFILL. `!stall && !flush` → RUN.
  - REFILL (IF/ID holds a squashed slot): `stall` → HELD, which is legal but only bubbles an invalid slot. `flush` → REFILL. Otherwise → RUN.
- **Encoding:** RUN=0, HELD=1, REFILL=2. Encoding 3 is unreachable and recovers to RUN at the next edge.
- **Invalid slot.** When `ifid_valid`=0, the instruction is a NOP and `idex_valid` propagates 0 with it.

## Timing
- All outputs are registered. Latency is 1 cycle from input to IF/ID and 2 cycles from fetch to ID/EX.
- `stall` is combinational from `idex_rt`/`idex_memread` and `ifid_instr`. The block treats it as valid before the edge and adds no cycle of delay.
- **Load-use case.**
  - Cycle n: load in ID/EX with a dependent instruction in IF/ID, so `stall`=1.
  - Edge n+1: bubble in ID/EX, so `idex_memread`=0 and `stall` drops.
  - Edge n+2: the dependent instruction enters ID/EX.
  - A single load-use hazard therefore costs exactly 1 cycle.
- **Reset mid-stall or mid-flush:** everything takes its reset values at that edge. No pending flush is remembered.

## Structure
- Shared package `pipe_pkg`:
  - `NOP_INSTR`=0, `PC_STEP`=4, `RESET_PC`=0.
  - The `front_state_t` enum.
  - Field indices for `CTRL_W` (REGWRITE=0, MEMWRITE=1).
- Sub-module `sat_counter` (parameterised width, `inc` input, synchronous clear), instantiated twice, plus a narrow instance for the stall run counter.
- The FSM and the datapath registers live in the top module.

## Test plan
- **Straight-line fetch.** Reset, then 4 cycles with `instr_in`=0x8C080000… → `pc` goes 0,4,8,12,16; `ifid_valid`=1 from cycle 1; `idex_valid`=1 from cycle 2.
- **Single load-use.** `stall`=1 for 1 cycle with `pc`=0x10 → `pc` holds at 0x10 for one edge; `idex_ctrl`=0 and `idex_valid`=0 for one cycle; `stall_cnt`=1; `state` goes RUN→HELD→RUN.
- **Taken branch.** `flush`=1 with `branch_target`=0x43 → `pc`=0x40; `ifid_instr`=0 and `ifid_valid`=0; `flush_cnt`=1; `state`=REFILL, then RUN.
- **Simultaneous stall and flush.** Both =1 → `pc` holds; `flush_cnt` unchanged; `state`=HELD. Next cycle with `flush` only → `pc`=`branch_target`.
- **Watchdog and saturation.** `stall` held 4 cycles with `MAX_STALL`=4 → `hang_err`=1 and stays 1 after `stall` drops. With `CNT_W`=4 and 20 stall cycles → `stall_cnt`=15.
- **Reset mid-stall and PC wrap.** Assert `reset` during HELD → all outputs take reset values at the next edge. Force `pc`=0xFFFFFFFC → next `pc`=0.
